// File: rtl/frame_packer_pkg.sv
// frame_packer_pkg: shared constants and types for the 48-word frame packer.
// Provides word/frame/index types, the FILL/FULL state enum and counter widths.
package frame_packer_pkg;

    localparam int WORD_W  = 10;
    localparam int N_WORDS = 48;
    localparam int IDX_W   = $clog2(N_WORDS);
    localparam int CNT_W   = 16;

    typedef logic [WORD_W-1:0]               word_t;
    typedef logic [N_WORDS-1:0][WORD_W-1:0]  frame_t;
    typedef logic [IDX_W-1:0]                idx_t;
    typedef logic [CNT_W-1:0]                cnt_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam idx_t LAST_IDX = idx_t'(N_WORDS - 1);

endpackage

// File: rtl/frame_packer_ctr.sv
// frame_packer_ctr: slot index counter for the frame packer.
// Ports: clk, rst (async high), inc, clr -> idx (current slot), last (idx at final slot).
module frame_packer_ctr
    import frame_packer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output idx_t idx,
    output logic last
);

    assign last = (idx == LAST_IDX);

    // Wraps to slot 0 after the final slot so the next frame starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + idx_t'(1);
        end
    end

endmodule

// File: rtl/frame_packer.sv
// frame_packer: packs 48 10-bit words into one 480-bit frame over valid/ready handshakes.
// Ports: clk, rst (async high); in_valid/in_ready/in_data/in_flush word side;
// frame_valid/frame_ready/frame_data frame side; frame_cnt counts handed-off frames.
// Build option FRAME_PACKER_PARITY_EN adds in_parity and sticky frame_perr.
module frame_packer
    import frame_packer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  word_t in_data,
    input  logic  in_flush,
`ifdef FRAME_PACKER_PARITY_EN
    input  logic  in_parity,
    output logic  frame_perr,
`endif
    output logic  frame_valid,
    input  logic  frame_ready,
    output frame_t frame_data,
    output cnt_t  frame_cnt
);

    state_t state_q;
    state_t state_d;
    frame_t frame_q;
    cnt_t   cnt_q;
    idx_t   idx;
    logic   last;
    logic   accept;
    logic   handoff;
    logic   flush_fill;

    // in_ready is held low while reset is asserted so every output reads 0.
    assign in_ready    = (state_q == FILL) && !in_flush && !rst;
    assign accept      = in_valid && in_ready;
    assign frame_valid = (state_q == FULL);
    assign handoff     = frame_valid && frame_ready;
    assign flush_fill  = in_flush && (state_q == FILL);

    assign frame_data  = frame_q;
    assign frame_cnt   = cnt_q;

    frame_packer_ctr u_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (flush_fill),
        .idx  (idx),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (accept && last) state_d = FULL;
            FULL: if (frame_ready)    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Slots are only ever overwritten, never cleared outside reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else if (accept) begin
            frame_q[idx] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (handoff) begin
            cnt_q <= cnt_q + cnt_t'(1);
        end
    end

`ifdef FRAME_PACKER_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (handoff || flush_fill) begin
            perr_q <= 1'b0;
        end else if (accept && (^{in_parity, in_data})) begin
            perr_q <= 1'b1;
        end
    end

    assign frame_perr = perr_q;
`endif

endmodule
